// File: rtl/polar_pkg.sv
// Polar code shared constants and FSM state type, common to the encoder and decoder.
// Defaults describe the N=8, K=4 code with frozen positions 0,1,2,4.
package polar_pkg;

  localparam int N    = 8;
  localparam int STEP = 3;
  localparam int SIZE = 20;
  localparam int K    = 4;

  localparam logic [N-1:0]    FROZEN_MASK = 8'h17;
  localparam logic [SIZE-1:0] LLR_MAG     = 20'h00100;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ENCODE = 2'd1,
    HOLD   = 2'd2
  } enc_state_t;

endpackage

// File: rtl/polar_encoder_if.sv
// Frame handshake bundle for the polar encoder: info in with valid/ready, codeword out with valid/ready.
// llr_out only exists when POLAR_ENC_LLR_OUT_EN is defined.
interface polar_encoder_if #(
  parameter int N    = 8,
  parameter int K    = 4,
  parameter int SIZE = 20
);

  logic           in_valid;
  logic           in_ready;
  logic [K-1:0]   info;
  logic           out_valid;
  logic           out_ready;
  logic [N-1:0]   codeword;
`ifdef POLAR_ENC_LLR_OUT_EN
  logic [N*SIZE-1:0] llr_out;

  modport master (output in_valid, info, out_ready,
                  input  in_ready, out_valid, codeword, llr_out);
  modport slave  (input  in_valid, info, out_ready,
                  output in_ready, out_valid, codeword, llr_out);
`else
  modport master (output in_valid, info, out_ready,
                  input  in_ready, out_valid, codeword);
  modport slave  (input  in_valid, info, out_ready,
                  output in_ready, out_valid, codeword);
`endif

endinterface

// File: rtl/polar_enc_stage.sv
// One combinational polar butterfly stage at distance D: x[i] ^= x[i+D] where bit log2(D) of i is clear.
// Zero latency; no flow control.
module polar_enc_stage #(
  parameter int N = 8,
  parameter int D = 1
) (
  input  logic [N-1:0] x_in,
  output logic [N-1:0] x_out
);

  for (genvar i = 0; i < N; i++) begin : g_bit
    if ((i & D) == 0) begin : g_xor
      assign x_out[i] = x_in[i] ^ x_in[i+D];
    end else begin : g_pass
      assign x_out[i] = x_in[i];
    end
  end

endmodule

// File: rtl/polar_encoder.sv
// Polar encoder (x = u * F^{(x)STEP}); one butterfly stage per cycle, codeword valid STEP cycles after accept.
// One frame in flight; result held until out_ready. POLAR_ENC_LLR_OUT_EN adds a +/-LLR_MAG llr_out view.
module polar_encoder #(
  parameter int                N           = polar_pkg::N,
  parameter int                STEP        = polar_pkg::STEP,
  parameter int                SIZE        = polar_pkg::SIZE,
  parameter int                K           = polar_pkg::K,
  parameter logic [N-1:0]      FROZEN_MASK = polar_pkg::FROZEN_MASK,
  parameter logic [SIZE-1:0]   LLR_MAG     = polar_pkg::LLR_MAG
) (
  input  logic            clk,
  input  logic            rst_n,
  polar_encoder_if.slave  bus
);

  import polar_pkg::*;

  localparam int CNT_W = (STEP > 1) ? $clog2(STEP) : 1;

  enc_state_t         state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [N-1:0]       x_q;
  logic               in_ready_q;
  logic               out_valid_q;

  logic [N-1:0]       u_load;
  logic [N-1:0]       step_x;
  logic [N-1:0]       stage_out [STEP];
  int                 k;

  // Info bits fill the non-frozen positions in ascending order.
  always_comb begin
    u_load = '0;
    k      = 0;
    for (int j = 0; j < N; j++) begin
      if (!FROZEN_MASK[j]) begin
        if (k < K) u_load[j] = bus.info[k];
        k++;
      end
    end
  end

  for (genvar s = 0; s < STEP; s++) begin : g_stage
    polar_enc_stage #(
      .N (N),
      .D (1 << s)
    ) u_stage (
      .x_in  (x_q),
      .x_out (stage_out[s])
    );
  end

  always_comb begin
    step_x = stage_out[0];
    for (int s = 1; s < STEP; s++) begin
      if (cnt_q == CNT_W'(s)) step_x = stage_out[s];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      x_q         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            x_q        <= u_load;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= ENCODE;
          end
        end
        ENCODE: begin
          x_q <= step_x;
          if (cnt_q == CNT_W'(STEP - 1)) begin
            state_q     <= HOLD;
            out_valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        HOLD: begin
          // Retiring edge never accepts; the next frame waits for IDLE.
          if (bus.out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          cnt_q       <= '0;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.codeword  = x_q;

`ifdef POLAR_ENC_LLR_OUT_EN
  localparam logic [SIZE-1:0] LLR_NEG = ~LLR_MAG + 1'b1;

  logic [N*SIZE-1:0] llr_vec;

  always_comb begin
    llr_vec = '0;
    for (int i = 0; i < N; i++) begin
      llr_vec[i*SIZE +: SIZE] = x_q[i] ? LLR_NEG : LLR_MAG;
    end
  end

  assign bus.llr_out = llr_vec;
`endif

endmodule

// File: tb/tb_polar_encoder.sv
// Self-checking bench for polar_encoder: directed vectors, stall, mid-frame reset and random traffic
// against a subset-XOR reference model. LLR checks are active when POLAR_ENC_LLR_OUT_EN is defined.
module tb_polar_encoder;

  logic clk;
  logic rst_n;

  int n_cmp = 0;
  int n_err = 0;

  polar_encoder_if #(.N(8), .K(4), .SIZE(20)) bus ();

  polar_encoder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // x[i] = XOR of u[j] over every j whose bits include those of i.
  function automatic logic [7:0] ref_encode(input logic [3:0] inf);
    int         pos [4] = '{3, 5, 6, 7};
    logic [7:0] u;
    logic [7:0] x;
    u = '0;
    for (int b = 0; b < 4; b++) u[pos[b]] = inf[b];
    for (int i = 0; i < 8; i++) begin
      x[i] = 1'b0;
      for (int j = 0; j < 8; j++) begin
        if ((j & i) == i) x[i] = x[i] ^ u[j];
      end
    end
    return x;
  endfunction

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.in_valid  = 1'b1;
    bus.info      = 4'hF;
    bus.out_ready = 1'b0;
    step();
    step();
    bus.in_valid = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    n_cmp++;
    if (bus.in_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready);
    end
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin
      n_err++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid);
    end
    n_cmp++;
    if (bus.codeword !== 8'h00) begin
      n_err++; $display("FAIL reset_codeword got=%h exp=00", bus.codeword);
    end
`ifdef POLAR_ENC_LLR_OUT_EN
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (bus.llr_out[i*20 +: 20] !== 20'h00100) begin
        n_err++; $display("FAIL reset_llr[%0d] got=%h exp=00100", i, bus.llr_out[i*20 +: 20]);
      end
    end
`endif
  endtask

  task automatic test_vectors();
    logic [3:0] infos [4] = '{4'b0001, 4'b1000, 4'b1111, 4'b0000};
    logic [7:0] exps  [4] = '{8'h0F, 8'hFF, 8'h96, 8'h00};
    for (int t = 0; t < 4; t++) begin
      n_cmp++;
      if (bus.in_ready !== 1'b1) begin
        n_err++; $display("FAIL vec%0d_in_ready got=%b exp=1", t, bus.in_ready);
      end
      bus.in_valid = 1'b1;
      bus.info     = infos[t];
      step();
      bus.in_valid = 1'b0;
      bus.info     = 4'h0;
      for (int c = 0; c < 3; c++) begin
        n_cmp++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
          n_err++;
          $display("FAIL vec%0d_latency c=%0d got out_valid=%b in_ready=%b exp 0/0",
                   t, c, bus.out_valid, bus.in_ready);
        end
        step();
      end
      n_cmp++;
      if (bus.out_valid !== 1'b1) begin
        n_err++; $display("FAIL vec%0d_out_valid got=%b exp=1", t, bus.out_valid);
      end
      n_cmp++;
      if (bus.codeword !== exps[t]) begin
        n_err++; $display("FAIL vec%0d_codeword got=%h exp=%h", t, bus.codeword, exps[t]);
      end
`ifdef POLAR_ENC_LLR_OUT_EN
      if (t == 0) begin
        for (int i = 0; i < 8; i++) begin
          n_cmp++;
          if (bus.llr_out[i*20 +: 20] !== ((i < 4) ? 20'hFFF00 : 20'h00100)) begin
            n_err++; $display("FAIL llr_slice%0d got=%h", i, bus.llr_out[i*20 +: 20]);
          end
        end
      end
`endif
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;
      n_cmp++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
        n_err++;
        $display("FAIL vec%0d_retire got out_valid=%b in_ready=%b exp 0/1",
                 t, bus.out_valid, bus.in_ready);
      end
    end
  endtask

  task automatic test_hold_stall();
    logic [3:0] inf1, inf2;
    logic [7:0] exp1, exp2;
    inf1 = 4'($urandom_range(1, 15));
    inf2 = 4'($urandom_range(0, 15));
    exp1 = ref_encode(inf1);
    exp2 = ref_encode(inf2);
    bus.in_valid = 1'b1;
    bus.info     = inf1;
    step();
    bus.info = inf2;
    step();
    step();
    step();
    for (int c = 0; c < 5; c++) begin
      n_cmp++;
      if (bus.out_valid !== 1'b1 || bus.codeword !== exp1 || bus.in_ready !== 1'b0) begin
        n_err++;
        $display("FAIL stall_c%0d got v=%b cw=%h rdy=%b exp v=1 cw=%h rdy=0",
                 c, bus.out_valid, bus.codeword, bus.in_ready, exp1);
      end
      step();
    end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    n_cmp++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL stall_release got v=%b rdy=%b exp v=0 rdy=1", bus.out_valid, bus.in_ready);
    end
    step();
    bus.in_valid = 1'b0;
    step();
    step();
    step();
    n_cmp++;
    if (bus.out_valid !== 1'b1 || bus.codeword !== exp2) begin
      n_err++;
      $display("FAIL stall_next got v=%b cw=%h exp v=1 cw=%h", bus.out_valid, bus.codeword, exp2);
    end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_encode();
    bus.in_valid = 1'b1;
    bus.info     = 4'b0001;
    step();
    bus.in_valid = 1'b0;
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    n_cmp++;
    if (bus.out_valid !== 1'b0 || bus.codeword !== 8'h00 || bus.in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL midrst got v=%b cw=%h rdy=%b exp v=0 cw=00 rdy=1",
               bus.out_valid, bus.codeword, bus.in_ready);
    end
    step();
    step();
    step();
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin
      n_err++; $display("FAIL midrst_discard got v=%b exp=0", bus.out_valid);
    end
    bus.in_valid = 1'b1;
    bus.info     = 4'b1111;
    step();
    bus.in_valid = 1'b0;
    step();
    step();
    step();
    n_cmp++;
    if (bus.out_valid !== 1'b1 || bus.codeword !== 8'h96) begin
      n_err++;
      $display("FAIL midrst_next got v=%b cw=%h exp v=1 cw=96", bus.out_valid, bus.codeword);
    end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [7:0] exp_q [$];
    logic [7:0] expv;
    int         accepted = 0;
    int         retired  = 0;
    int         cycles   = 0;
    bit         acc, ret;
    while ((accepted < 1000 || exp_q.size() != 0) && cycles < 40000) begin
      bus.in_valid  = (accepted < 1000) && ($urandom_range(0, 3) != 0);
      bus.info      = 4'($urandom_range(0, 15));
      bus.out_ready = ($urandom_range(0, 2) != 0);
      acc = bus.in_valid && bus.in_ready;
      ret = bus.out_valid && bus.out_ready;
      if (ret) begin
        retired++;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++; $display("FAIL rand_extra_output cw=%h with no frame outstanding", bus.codeword);
        end else begin
          expv = exp_q.pop_front();
          if (bus.codeword !== expv) begin
            n_err++;
            $display("FAIL rand_codeword frame=%0d got=%h exp=%h", retired, bus.codeword, expv);
          end
        end
      end
      if (acc) begin
        accepted++;
        exp_q.push_back(ref_encode(bus.info));
      end
      step();
      cycles++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    n_cmp++;
    if (accepted != 1000 || retired != 1000) begin
      n_err++;
      $display("FAIL rand_counts accepted=%0d retired=%0d exp 1000/1000 (cycles=%0d)",
               accepted, retired, cycles);
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.info      = 4'h0;
    bus.out_ready = 1'b0;
    #1;
    test_reset();
    test_vectors();
    test_hold_stall();
    test_reset_mid_encode();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
